// File: rtl/mem_axi_bridge_if.sv
// AXI4 master channel bundle between the bridge and the DDR controller port.
// The bridge takes the master modport and the memory takes the slave modport.
interface mem_axi_bridge_if #(
   parameter int MEM_DATA_LEN = 64,
   parameter int AXI_ADDR_LEN = 32
);
   logic [AXI_ADDR_LEN-1:0] m_araddr;
   logic [7:0]              m_arlen;
   logic                    m_arvalid;
   logic                    m_arready;
   logic [MEM_DATA_LEN-1:0] m_rdata;
   logic                    m_rlast;
   logic                    m_rvalid;
   logic                    m_rready;
   logic [AXI_ADDR_LEN-1:0] m_awaddr;
   logic [7:0]              m_awlen;
   logic                    m_awvalid;
   logic                    m_awready;
   logic [MEM_DATA_LEN-1:0] m_wdata;
   logic                    m_wlast;
   logic                    m_wvalid;
   logic                    m_wready;
   logic [1:0]              m_bresp;
   logic                    m_bvalid;
   logic                    m_bready;

   modport master (
      output m_araddr, m_arlen, m_arvalid, input m_arready,
      input  m_rdata, m_rlast, m_rvalid, output m_rready,
      output m_awaddr, m_awlen, m_awvalid, input m_awready,
      output m_wdata, m_wlast, m_wvalid, input m_wready,
      input  m_bresp, m_bvalid, output m_bready
   );

   modport slave (
      input  m_araddr, m_arlen, m_arvalid, output m_arready,
      output m_rdata, m_rlast, m_rvalid, input m_rready,
      input  m_awaddr, m_awlen, m_awvalid, output m_awready,
      input  m_wdata, m_wlast, m_wvalid, output m_wready,
      output m_bresp, m_bvalid, input m_bready
   );
endinterface

// File: rtl/mem_axi_bridge.sv
// Serialises the image stage's single-request read/write bursts into AXI4
// master transactions; one transaction in flight, round-robin on ties.
module mem_axi_bridge #(
   parameter int MEM_DATA_LEN   = 64,
   parameter int ADDR_LEN       = 32,
   parameter int AXI_ADDR_LEN   = 32,
   parameter int ADDR_SHIFT     = 3,
   parameter int MAX_BURST      = 256,
   parameter int TIMEOUT_CYCLES = 4095
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rd_valid,
   input  logic [9:0]              rd_burst_len,
   input  logic [ADDR_LEN-1:0]     rd_addr,
   output logic                    rd_ready,
   output logic [MEM_DATA_LEN-1:0] rd_data,
   output logic                    rd_burst_finish,
   input  logic                    wr_valid,
   input  logic [9:0]              wr_burst_len,
   input  logic [ADDR_LEN-1:0]     wr_addr,
   input  logic [MEM_DATA_LEN-1:0] wr_data,
   output logic                    wr_ready,
   output logic                    wr_burst_finish,
   mem_axi_bridge_if.master        axi,
   output logic                    error
);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [9:0]    MAX_LEN = 10'(MAX_BURST);
   localparam logic [TW-1:0] TMO     = TW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE} state_t;
   state_t state, nxt;

   logic [BW-1:0] blen, bcnt, rd_clamp, wr_clamp;
   logic [TW-1:0] tcnt;
   logic          cur_wr, last_wr, at_last, hs, rd_oor, wr_oor;

   function automatic logic [BW-1:0] clamp_len(input logic [9:0] len);
      if (len == 10'd0)         return BW'(1);
      else if (len > MAX_LEN)   return BW'(MAX_BURST);
      else                      return BW'(len);
   endfunction

   assign rd_clamp = clamp_len(rd_burst_len);
   assign wr_clamp = clamp_len(wr_burst_len);
   assign rd_oor   = (rd_burst_len == 10'd0) || (rd_burst_len > MAX_LEN);
   assign wr_oor   = (wr_burst_len == 10'd0) || (wr_burst_len > MAX_LEN);
   // one beat counter serves both directions since only one burst is ever active
   assign at_last  = (bcnt == blen - 1'b1);
   assign hs = (axi.m_arvalid & axi.m_arready) | (axi.m_rready & axi.m_rvalid) |
               (axi.m_awvalid & axi.m_awready) | (axi.m_wvalid & axi.m_wready) |
               (axi.m_bready & axi.m_bvalid);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt             = state;
      axi.m_arvalid   = 1'b0;
      axi.m_rready    = 1'b0;
      axi.m_awvalid   = 1'b0;
      axi.m_wvalid    = 1'b0;
      axi.m_wlast     = 1'b0;
      axi.m_wdata     = '0;
      axi.m_bready    = 1'b0;
      wr_ready        = 1'b0;
      rd_burst_finish = 1'b0;
      wr_burst_finish = 1'b0;
      case (state)
         IDLE: begin
            // on a tie the grant goes to whichever side did not win last time
            if (rd_valid && (!wr_valid || last_wr)) nxt = RD_ADDR;
            else if (wr_valid)                      nxt = WR_ADDR;
         end
         RD_ADDR: begin
            axi.m_arvalid = 1'b1;
            if (axi.m_arready) nxt = RD_DATA;
         end
         RD_DATA: begin
            axi.m_rready = 1'b1;
            if (axi.m_rvalid && axi.m_rlast) nxt = DONE;
         end
         WR_ADDR: begin
            axi.m_awvalid = 1'b1;
            if (axi.m_awready) nxt = WR_DATA;
         end
         WR_DATA: begin
            axi.m_wvalid = 1'b1;
            axi.m_wdata  = wr_data;
            axi.m_wlast  = at_last;
            wr_ready     = axi.m_wready;
            if (axi.m_wready && at_last) nxt = WR_RESP;
         end
         WR_RESP: begin
            axi.m_bready = 1'b1;
            if (axi.m_bvalid) nxt = DONE;
         end
         DONE: begin
            rd_burst_finish = !cur_wr;
            wr_burst_finish = cur_wr;
            nxt             = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         axi.m_araddr <= '0;
         axi.m_arlen  <= '0;
         axi.m_awaddr <= '0;
         axi.m_awlen  <= '0;
         rd_ready     <= 1'b0;
         rd_data      <= '0;
         blen         <= '0;
         bcnt         <= '0;
         cur_wr       <= 1'b0;
         last_wr      <= 1'b1;
         tcnt         <= '0;
         error        <= 1'b0;
      end else begin
         rd_ready <= 1'b0;
         if (state == IDLE && nxt == RD_ADDR) begin
            axi.m_araddr <= AXI_ADDR_LEN'({rd_addr, {ADDR_SHIFT{1'b0}}});
            axi.m_arlen  <= 8'(rd_clamp - 1'b1);
            blen         <= rd_clamp;
            bcnt         <= '0;
            cur_wr       <= 1'b0;
            if (rd_oor) error <= 1'b1;
         end
         if (state == IDLE && nxt == WR_ADDR) begin
            axi.m_awaddr <= AXI_ADDR_LEN'({wr_addr, {ADDR_SHIFT{1'b0}}});
            axi.m_awlen  <= 8'(wr_clamp - 1'b1);
            blen         <= wr_clamp;
            bcnt         <= '0;
            cur_wr       <= 1'b1;
            if (wr_oor) error <= 1'b1;
         end
         if (state == RD_DATA && axi.m_rvalid) begin
            rd_ready <= 1'b1;
            rd_data  <= axi.m_rdata;
            bcnt     <= bcnt + 1'b1;
            // slave's rlast must land exactly on our expected count; the burst still ends on rlast
            if (axi.m_rlast != at_last) error <= 1'b1;
         end
         if (state == WR_DATA && axi.m_wready) bcnt <= bcnt + 1'b1;
         if (state == WR_RESP && axi.m_bvalid && axi.m_bresp != 2'b00) error <= 1'b1;
         if (state == DONE) last_wr <= cur_wr;
         // stall watchdog only flags; aborting would break the AXI protocol
         if (state == IDLE || hs) tcnt <= '0;
         else if (tcnt != TMO) begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TMO - 1'b1) error <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed bench for mem_axi_bridge: a small AXI slave responder plus
// per-feature tasks with hand-computed expectations.
module tb_mem_axi_bridge;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rd_valid = 1'b0;
   logic [9:0]  rd_burst_len = '0;
   logic [31:0] rd_addr = '0;
   logic        rd_ready;
   logic [63:0] rd_data;
   logic        rd_burst_finish;
   logic        wr_valid = 1'b0;
   logic [9:0]  wr_burst_len = '0;
   logic [31:0] wr_addr = '0;
   logic [63:0] wr_data = '0;
   logic        wr_ready;
   logic        wr_burst_finish;
   logic        error;
   logic        any_out;
   int          vecs = 0;
   int          errs = 0;

   mem_axi_bridge_if #(.MEM_DATA_LEN(64), .AXI_ADDR_LEN(32)) axi ();

   mem_axi_bridge #(
      .MEM_DATA_LEN(64), .ADDR_LEN(32), .AXI_ADDR_LEN(32), .ADDR_SHIFT(3),
      .MAX_BURST(256), .TIMEOUT_CYCLES(4095)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_valid(rd_valid), .rd_burst_len(rd_burst_len), .rd_addr(rd_addr),
      .rd_ready(rd_ready), .rd_data(rd_data), .rd_burst_finish(rd_burst_finish),
      .wr_valid(wr_valid), .wr_burst_len(wr_burst_len), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ready(wr_ready), .wr_burst_finish(wr_burst_finish),
      .axi(axi), .error(error)
   );

   always #5 clk = ~clk;

   assign any_out = |{rd_ready, rd_data, rd_burst_finish, wr_ready, wr_burst_finish, error,
                      axi.m_araddr, axi.m_arlen, axi.m_arvalid, axi.m_rready,
                      axi.m_awaddr, axi.m_awlen, axi.m_awvalid, axi.m_wdata,
                      axi.m_wlast, axi.m_wvalid, axi.m_bready};

   task automatic apply_reset();
      rst = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0;
      axi.m_arready = 1'b0; axi.m_awready = 1'b0; axi.m_wready = 1'b0;
      axi.m_rvalid = 1'b0; axi.m_rlast = 1'b0; axi.m_rdata = '0;
      axi.m_bvalid = 1'b0; axi.m_bresp = 2'b00;
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   // Zero-wait slave for one granted transaction; n = read beats to return.
   task automatic slave_run(input int n, input logic [1:0] resp, output bit is_wr,
                            output int beats, output logic [7:0] alen, output int lat,
                            output bit fin);
      bit seen;
      int rb;
      seen = 0; is_wr = 0; beats = 0; alen = '0; lat = 0; fin = 0; rb = 0;
      axi.m_arready = 1'b1; axi.m_awready = 1'b1; axi.m_wready = 1'b1;
      for (int c = 1; c <= 700 && !fin; c++) begin
         @(negedge clk);
         if (!seen && (axi.m_arvalid || axi.m_awvalid)) begin
            seen = 1; lat = c; is_wr = axi.m_awvalid;
            alen = axi.m_awvalid ? axi.m_awlen : axi.m_arlen;
         end
         beats += int'(rd_ready) + int'(wr_ready);
         wr_data      = 64'hB000 + 64'(beats);
         axi.m_rvalid = axi.m_rready;
         axi.m_rlast  = axi.m_rready && (rb == n - 1);
         axi.m_rdata  = 64'hA000 + 64'(rb);
         if (axi.m_rready) rb++;
         axi.m_bvalid = axi.m_bready;
         axi.m_bresp  = resp;
         if (rd_burst_finish) begin rd_valid = 1'b0; fin = 1; end
         if (wr_burst_finish) begin wr_valid = 1'b0; fin = 1; end
      end
      axi.m_rvalid = 1'b0; axi.m_rlast = 1'b0; axi.m_bvalid = 1'b0; axi.m_bresp = 2'b00;
   endtask

   task automatic test_reset();
      apply_reset();
      vecs++;
      if (any_out !== 1'b0) begin errs++; $display("FAIL reset_outputs got %b want 0", any_out); end
      @(negedge clk);
      vecs++;
      if (any_out !== 1'b0) begin errs++; $display("FAIL reset_idle got %b want 0", any_out); end
   endtask

   task automatic test_single_read();
      rd_valid = 1'b1; rd_addr = 32'h100; rd_burst_len = 10'd1; axi.m_arready = 1'b1;
      @(negedge clk);
      vecs++;
      if ({axi.m_arvalid, axi.m_araddr, axi.m_arlen} !== {1'b1, 32'h800, 8'h00}) begin
         errs++; $display("FAIL rd_ar got %b/%h/%h want 1/800/00", axi.m_arvalid, axi.m_araddr, axi.m_arlen);
      end
      @(negedge clk);
      vecs++;
      if ({axi.m_rready, axi.m_arvalid} !== 2'b10) begin
         errs++; $display("FAIL rd_rready got %b want 10", {axi.m_rready, axi.m_arvalid});
      end
      axi.m_rvalid = 1'b1; axi.m_rlast = 1'b1; axi.m_rdata = 64'h1122_3344_5566_7788;
      @(negedge clk);
      axi.m_rvalid = 1'b0; axi.m_rlast = 1'b0;
      vecs++;
      if ({rd_ready, rd_data} !== {1'b1, 64'h1122_3344_5566_7788}) begin
         errs++; $display("FAIL rd_beat got %b/%h want 1/1122334455667788", rd_ready, rd_data);
      end
      vecs++;
      if (rd_burst_finish !== 1'b1) begin errs++; $display("FAIL rd_finish got %b want 1", rd_burst_finish); end
      rd_valid = 1'b0;
      @(negedge clk);
      vecs++;
      if ({rd_burst_finish, rd_ready, error} !== 3'b000) begin
         errs++; $display("FAIL rd_finish_width got %b want 000", {rd_burst_finish, rd_ready, error});
      end
   endtask

   task automatic test_write_burst();
      logic [63:0] d [4];
      int beat, strobes;
      d[0] = 64'hD0; d[1] = 64'hD1; d[2] = 64'hD2; d[3] = 64'hD3;
      wr_valid = 1'b1; wr_addr = 32'h10; wr_burst_len = 10'd4; wr_data = d[0];
      axi.m_awready = 1'b1; axi.m_wready = 1'b0;
      @(negedge clk);
      vecs++;
      if ({axi.m_awvalid, axi.m_awaddr, axi.m_awlen} !== {1'b1, 32'h80, 8'h03}) begin
         errs++; $display("FAIL wr_aw got %b/%h/%h want 1/80/03", axi.m_awvalid, axi.m_awaddr, axi.m_awlen);
      end
      @(negedge clk);
      beat = 0; strobes = 0;
      for (int c = 0; c < 7; c++) begin
         if (c > 0) @(negedge clk);
         axi.m_wready = (c % 2 == 0);
         wr_data = d[beat];
         #1;
         vecs++;
         if ({axi.m_wvalid, axi.m_wdata, axi.m_wlast} !== {1'b1, d[beat], beat == 3}) begin
            errs++; $display("FAIL wr_beat%0d got %b/%h/%b want 1/%h/%b", c, axi.m_wvalid,
                             axi.m_wdata, axi.m_wlast, d[beat], beat == 3);
         end
         vecs++;
         if (wr_ready !== (c % 2 == 0)) begin
            errs++; $display("FAIL wr_ready%0d got %b want %b", c, wr_ready, c % 2 == 0);
         end
         strobes += int'(wr_ready);
         if (c % 2 == 0) beat++;
      end
      @(negedge clk);
      axi.m_wready = 1'b0;
      vecs++;
      if ({axi.m_bready, axi.m_wvalid, wr_burst_finish} !== 3'b100) begin
         errs++; $display("FAIL wr_resp got %b want 100", {axi.m_bready, axi.m_wvalid, wr_burst_finish});
      end
      vecs++;
      if (strobes !== 4) begin errs++; $display("FAIL wr_strobes got %0d want 4", strobes); end
      axi.m_bvalid = 1'b1; axi.m_bresp = 2'b00;
      @(negedge clk);
      axi.m_bvalid = 1'b0;
      vecs++;
      if ({wr_burst_finish, rd_burst_finish} !== 2'b10) begin
         errs++; $display("FAIL wr_finish got %b want 10", {wr_burst_finish, rd_burst_finish});
      end
      wr_valid = 1'b0;
      @(negedge clk);
      vecs++;
      if ({wr_burst_finish, error} !== 2'b00) begin
         errs++; $display("FAIL wr_finish_width got %b want 00", {wr_burst_finish, error});
      end
   endtask

   task automatic test_round_robin();
      bit is_wr, fin;
      int beats, lat;
      logic [7:0] alen;
      rd_valid = 1'b1; wr_valid = 1'b1; rd_addr = 32'h200; wr_addr = 32'h300;
      rd_burst_len = 10'd2; wr_burst_len = 10'd3;
      slave_run(2, 2'b00, is_wr, beats, alen, lat, fin);
      vecs++;
      if ({is_wr, fin, alen} !== {1'b0, 1'b1, 8'd1} || beats != 2) begin
         errs++; $display("FAIL rr_tie1 got wr=%b fin=%b len=%0d beats=%0d want wr=0 fin=1 len=1 beats=2", is_wr, fin, alen, beats);
      end
      slave_run(3, 2'b00, is_wr, beats, alen, lat, fin);
      vecs++;
      if ({is_wr, fin, alen} !== {1'b1, 1'b1, 8'd2} || beats != 3) begin
         errs++; $display("FAIL rr_second got wr=%b fin=%b len=%0d beats=%0d want wr=1 fin=1 len=2 beats=3", is_wr, fin, alen, beats);
      end
      vecs++;
      if (lat != 2) begin errs++; $display("FAIL rr_no_bubble got %0d want 2", lat); end
      rd_valid = 1'b1; wr_valid = 1'b1;
      slave_run(2, 2'b00, is_wr, beats, alen, lat, fin);
      vecs++;
      if ({is_wr, fin} !== 2'b01 || lat != 2) begin
         errs++; $display("FAIL rr_tie2 got wr=%b fin=%b lat=%0d want wr=0 fin=1 lat=2", is_wr, fin, lat);
      end
      slave_run(3, 2'b00, is_wr, beats, alen, lat, fin);
      vecs++;
      if ({is_wr, fin, error} !== 3'b110) begin
         errs++; $display("FAIL rr_tail got %b want 110", {is_wr, fin, error});
      end
   endtask

   task automatic test_bresp_error();
      bit is_wr, fin;
      int beats, lat;
      logic [7:0] alen;
      wr_valid = 1'b1; wr_addr = 32'h40; wr_burst_len = 10'd2;
      slave_run(2, 2'b10, is_wr, beats, alen, lat, fin);
      vecs++;
      if ({is_wr, fin} !== 2'b11 || beats != 2) begin
         errs++; $display("FAIL bresp_finish got wr=%b fin=%b beats=%0d want 1/1/2", is_wr, fin, beats);
      end
      vecs++;
      if (error !== 1'b1) begin errs++; $display("FAIL bresp_error got %b want 1", error); end
   endtask

   task automatic test_reset_mid_write();
      @(negedge clk);
      wr_valid = 1'b1; wr_addr = 32'h8; wr_burst_len = 10'd4; wr_data = 64'hDEAD;
      axi.m_awready = 1'b1; axi.m_wready = 1'b0;
      repeat (2) @(negedge clk);
      vecs++;
      if ({axi.m_wvalid, axi.m_wdata, error} !== {1'b1, 64'hDEAD, 1'b1}) begin
         errs++; $display("FAIL midwr_pre got %b/%h/%b want 1/dead/1", axi.m_wvalid, axi.m_wdata, error);
      end
      #2 rst = 1'b0;
      #1;
      vecs++;
      if (any_out !== 1'b0) begin errs++; $display("FAIL midwr_async got %b want 0", any_out); end
      @(negedge clk);
      wr_valid = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_timeout();
      bit is_wr, fin;
      int beats, lat;
      logic [7:0] alen;
      rd_valid = 1'b1; rd_addr = 32'h20; rd_burst_len = 10'd1; axi.m_arready = 1'b0;
      @(negedge clk);
      vecs++;
      if ({axi.m_arvalid, error} !== 2'b10) begin
         errs++; $display("FAIL tmo_start got %b want 10", {axi.m_arvalid, error});
      end
      repeat (4094) @(negedge clk);
      vecs++;
      if (error !== 1'b0) begin errs++; $display("FAIL tmo_early got %b want 0", error); end
      @(negedge clk);
      vecs++;
      if (error !== 1'b1) begin errs++; $display("FAIL tmo_hit got %b want 1", error); end
      slave_run(1, 2'b00, is_wr, beats, alen, lat, fin);
      vecs++;
      if ({is_wr, fin, error} !== 3'b011 || beats != 1) begin
         errs++; $display("FAIL tmo_complete got %b beats=%0d want 011 beats=1", {is_wr, fin, error}, beats);
      end
   endtask

   task automatic test_len_clamp();
      bit is_wr, fin;
      int beats, lat;
      logic [7:0] alen;
      apply_reset();
      @(negedge clk);
      vecs++;
      if (error !== 1'b0) begin errs++; $display("FAIL clamp_pre got %b want 0", error); end
      rd_valid = 1'b1; rd_addr = 32'h5; rd_burst_len = 10'd0;
      slave_run(1, 2'b00, is_wr, beats, alen, lat, fin);
      vecs++;
      if ({is_wr, fin, alen, error} !== {1'b0, 1'b1, 8'd0, 1'b1} || beats != 1) begin
         errs++; $display("FAIL clamp_len0 got wr=%b fin=%b len=%0d err=%b beats=%0d want 0/1/0/1/1", is_wr, fin, alen, error, beats);
      end
      wr_valid = 1'b1; wr_addr = 32'h1000; wr_burst_len = 10'd300;
      slave_run(256, 2'b00, is_wr, beats, alen, lat, fin);
      vecs++;
      if ({is_wr, fin, alen, error} !== {1'b1, 1'b1, 8'd255, 1'b1} || beats != 256) begin
         errs++; $display("FAIL clamp_len300 got wr=%b fin=%b len=%0d err=%b beats=%0d want 1/1/255/1/256", is_wr, fin, alen, error, beats);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_burst();
      test_round_robin();
      test_bresp_error();
      test_reset_mid_write();
      test_timeout();
      test_len_clamp();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
